// File: rtl/fx_narrow_pipe.sv
// rtl/fx_narrow_pipe.sv - two-stage signed fixed-point narrowing converter with overflow stats
module fx_narrow_pipe #(
  parameter int IW         = 14,
  parameter int IFRAC      = 6,
  parameter int OW         = 10,
  parameter int OFRAC      = 3,
  parameter int ROUND_MODE = 1,
  parameter int SAT_MODE   = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [OW-1:0]    o_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_sat,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             ovf_sticky,
  input  logic             clr
);
  localparam int D  = IFRAC - OFRAC;
  localparam int QW = IW - D + 1;
  localparam int TW = QW - OW + 1;

  logic [IW:0]       ext;
  logic [QW-1:0]     q_next;
  logic [QW-1:0]     s1_q;
  logic              s1_v;
  logic              in_fire;
  logic              load2;
  logic              ovf;
  logic [TW-1:0]     top;
  logic [OW-1:0]     d2;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_next;
  logic              sticky_next;

  // One extra sign bit gives headroom so the rounding add can never overflow.
  assign ext = {i_data[IW-1], i_data};

  generate
    if (D == 0) begin : g_pass
      assign q_next = ext;
    end else begin : g_round
      localparam logic [IW:0] HALF = (IW+1)'(1) << (D-1);
      logic [IW:0] bias;
      logic [IW:0] sum;
      always_comb begin
        case (ROUND_MODE)
          1:       bias = HALF;
          2:       bias = HALF - (IW+1)'(1) + (IW+1)'(ext[D]);
          default: bias = '0;
        endcase
        sum = ext + bias;
      end
      assign q_next = QW'(sum >> D);
    end
  endgenerate

  assign i_ready = rst_n && (!s1_v || !o_valid || o_ready);
  assign in_fire = i_valid && i_ready;
  assign load2   = s1_v && (!o_valid || o_ready);

  // In range only when every bit above the output sign bit matches it.
  assign top = s1_q[QW-1:OW-1];
  assign ovf = !((&top) || !(|top));

  always_comb begin
    d2 = s1_q[OW-1:0];
    if (SAT_MODE != 0 && ovf) begin
      d2 = s1_q[QW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end

  // Clear applies before the count so a coincident overflow lands as 1.
  always_comb begin
    cnt_base    = clr ? '0 : sat_cnt;
    cnt_next    = cnt_base;
    sticky_next = !clr && ovf_sticky;
    if (load2 && ovf) begin
      sticky_next = 1'b1;
      if (!(&cnt_base)) cnt_next = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_v       <= 1'b0;
      o_data     <= '0;
      o_sat      <= 1'b0;
      o_valid    <= 1'b0;
      sat_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (in_fire) s1_q <= q_next;
      s1_v <= in_fire || (s1_v && !load2);
      if (load2) begin
        o_data <= d2;
        o_sat  <= ovf;
      end
      o_valid    <= load2 || (o_valid && !o_ready);
      sat_cnt    <= cnt_next;
      ovf_sticky <= sticky_next;
    end
  end
endmodule

// File: tb/tb_fx_narrow_pipe.sv
// tb/tb_fx_narrow_pipe.sv - self-checking bench for fx_narrow_pipe across rounding/overflow modes
module tb_fx_narrow_pipe;
  logic        clk;
  logic        rst_n;
  logic [13:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic        clr;
  logic [9:0]  od [5];
  logic        ov [5];
  logic        os [5];
  logic        ir [5];
  logic        st [5];
  logic [15:0] sc [4];
  logic [1:0]  sc4;

  int checks = 0;
  int errors = 0;
  int rm_of [5] = '{0, 1, 2, 1, 1};
  int sm_of [5] = '{1, 1, 1, 0, 1};
  int cnt [5];

  fx_narrow_pipe #(.ROUND_MODE(0), .SAT_MODE(1)) u0 (.clk(clk), .rst_n(rst_n), .i_data(i_data),
    .i_valid(i_valid), .i_ready(ir[0]), .o_data(od[0]), .o_valid(ov[0]), .o_ready(o_ready),
    .o_sat(os[0]), .sat_cnt(sc[0]), .ovf_sticky(st[0]), .clr(clr));
  fx_narrow_pipe #(.ROUND_MODE(1), .SAT_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .i_data(i_data),
    .i_valid(i_valid), .i_ready(ir[1]), .o_data(od[1]), .o_valid(ov[1]), .o_ready(o_ready),
    .o_sat(os[1]), .sat_cnt(sc[1]), .ovf_sticky(st[1]), .clr(clr));
  fx_narrow_pipe #(.ROUND_MODE(2), .SAT_MODE(1)) u2 (.clk(clk), .rst_n(rst_n), .i_data(i_data),
    .i_valid(i_valid), .i_ready(ir[2]), .o_data(od[2]), .o_valid(ov[2]), .o_ready(o_ready),
    .o_sat(os[2]), .sat_cnt(sc[2]), .ovf_sticky(st[2]), .clr(clr));
  fx_narrow_pipe #(.ROUND_MODE(1), .SAT_MODE(0)) u3 (.clk(clk), .rst_n(rst_n), .i_data(i_data),
    .i_valid(i_valid), .i_ready(ir[3]), .o_data(od[3]), .o_valid(ov[3]), .o_ready(o_ready),
    .o_sat(os[3]), .sat_cnt(sc[3]), .ovf_sticky(st[3]), .clr(clr));
  fx_narrow_pipe #(.ROUND_MODE(1), .SAT_MODE(1), .CNT_W(2)) u4 (.clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_valid(i_valid), .i_ready(ir[4]), .o_data(od[4]), .o_valid(ov[4]),
    .o_ready(o_ready), .o_sat(os[4]), .sat_cnt(sc4), .ovf_sticky(st[4]), .clr(clr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sc_of(input int k);
    return (k == 4) ? int'(sc4) : int'(sc[k]);
  endfunction

  function automatic int cmax(input int k);
    return (k == 4) ? 3 : 65535;
  endfunction

  // Reference: real-valued x/2^D, rounded per mode, then range-reduced.
  function automatic void model(input int x, input int rm, input int sm, output int y, output bit s);
    real r;
    real fr;
    int  fl;
    int  q;
    r  = x / 8.0;
    fl = int'($floor(r));
    fr = r - fl;
    case (rm)
      0:       q = fl;
      1:       q = (fr >= 0.5) ? fl + 1 : fl;
      default: q = (fr > 0.5 || (fr == 0.5 && (fl % 2) != 0)) ? fl + 1 : fl;
    endcase
    s = (q > 511) || (q < -512);
    if (!s) y = q;
    else if (sm != 0) y = (q > 511) ? 511 : -512;
    else begin
      y = q & 1023;
      if (y >= 512) y = y - 1024;
    end
  endfunction

  function automatic int rand_sample();
    int edges [8] = '{8191, -8192, 4092, 4091, 4093, -4096, -4100, -4097};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 7)];
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int k = 0; k < 5; k++) cnt[k] = 0;
  endtask

  task automatic run_stream(input int n, input bit ramp);
    int sent = 0, got = 0, cyc = 0, occ = 0, x, y;
    bit s, held = 0, prev_stall = 0, in_f, out_f;
    logic [9:0] prev [5];
    int inq [$];
    pulse_clr();
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (!held) begin
        i_valid = (sent < n) && (ramp || $urandom_range(0, 3) != 0);
        i_data  = ramp ? 14'(sent * 8) : 14'(rand_sample());
      end
      o_ready = ramp ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        for (int k = 0; k < 5; k++) chk("hold_data", int'(od[k]), int'(prev[k]));
        chk("hold_valid", int'(ov[0]), 1);
      end
      chk("i_ready", int'(ir[0]), int'(!(occ == 2 && !o_ready)));
      in_f  = i_valid && ir[0];
      out_f = ov[0] && o_ready;
      if (ov[0] && inq.size() == 0) chk("spurious_out", 1, 0);
      if (out_f && inq.size() > 0) begin
        x = inq.pop_front();
        for (int k = 0; k < 5; k++) begin
          model(x, rm_of[k], sm_of[k], y, s);
          if (s) cnt[k]++;
          chk("stream_data", int'($signed(od[k])), y);
          chk("stream_sat", int'(os[k]), int'(s));
          chk("stream_cnt", sc_of(k), (cnt[k] > cmax(k)) ? cmax(k) : cnt[k]);
          chk("stream_sticky", int'(st[k]), int'(cnt[k] > 0));
        end
        got++;
      end
      prev_stall = ov[0] && !o_ready;
      prev = od;
      if (in_f) begin
        inq.push_back(int'($signed(i_data)));
        sent++;
      end
      held = i_valid && !ir[0];
      occ  = occ + int'(in_f) - int'(out_f);
    end
    if (got < n) chk("stream_timeout", got, n);
    i_valid = 1'b0;
    o_ready = 1'b1;
  endtask

  typedef struct {
    int din;
    int y [4];
    bit s [4];
  } vec_t;

  vec_t tbl [8];

  initial begin
    int lat;
    bit found;
    tbl[0] = '{20,    '{2, 3, 2, 3},         '{0, 0, 0, 0}};
    tbl[1] = '{-20,   '{-3, -2, -2, -2},     '{0, 0, 0, 0}};
    tbl[2] = '{12,    '{1, 2, 2, 2},         '{0, 0, 0, 0}};
    tbl[3] = '{8191,  '{511, 511, 511, 0},   '{1, 1, 1, 1}};
    tbl[4] = '{-8192, '{-512, -512, -512, 0},'{1, 1, 1, 1}};
    tbl[5] = '{4092,  '{511, 511, 511, -512},'{0, 1, 1, 1}};
    tbl[6] = '{0,     '{0, 0, 0, 0},         '{0, 0, 0, 0}};
    tbl[7] = '{-4,    '{-1, 0, 0, 0},        '{0, 0, 0, 0}};

    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b1; clr = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_i_ready", int'(ir[0]), 0);
    for (int k = 0; k < 5; k++) begin
      chk("rst_o_valid", int'(ov[k]), 0);
      chk("rst_o_data", int'(od[k]), 0);
      chk("rst_o_sat", int'(os[k]), 0);
      chk("rst_sat_cnt", sc_of(k), 0);
      chk("rst_sticky", int'(st[k]), 0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    chk("release_i_ready", int'(ir[0]), 1);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = 14'(tbl[v].din);
      found = 0; lat = 0;
      for (int c = 1; c <= 8 && !found; c++) begin
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        if (ov[0]) begin found = 1; lat = c; end
      end
      chk("vec_latency", lat, 2);
      for (int k = 0; k < 4; k++) begin
        chk("vec_data", int'($signed(od[k])), tbl[v].y[k]);
        chk("vec_sat", int'(os[k]), int'(tbl[v].s[k]));
      end
    end
    @(negedge clk); #1;
    chk("tbl_cnt_trunc", sc_of(0), 2);
    chk("tbl_cnt_halfup", sc_of(1), 3);
    chk("tbl_cnt_wrap", sc_of(3), 3);
    chk("tbl_sticky", int'(st[0]), 1);

    pulse_clr(); #1;
    chk("clr_cnt", sc_of(1), 0);
    chk("clr_sticky", int'(st[1]), 0);

    for (int n = 0; n < 5; n++) begin
      @(negedge clk); i_valid = 1'b1; i_data = 14'(8191);
    end
    @(negedge clk); i_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("cnt2_stuck", sc_of(4), 3);
    chk("cnt16_five", sc_of(1), 5);
    @(negedge clk); i_valid = 1'b1; i_data = 14'(8191);
    @(negedge clk); i_valid = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0; #1;
    chk("clr_count_cnt", sc_of(4), 1);
    chk("clr_count_sticky", int'(st[4]), 1);
    chk("clr_count_cnt16", sc_of(1), 1);
    chk("clr_count_osat", int'(os[4]), 1);
    repeat (3) @(negedge clk);

    run_stream(16, 1'b1);
    run_stream(300, 1'b0);

    @(negedge clk); o_ready = 1'b0; i_valid = 1'b1; i_data = 14'(8191);
    @(negedge clk); i_data = 14'(8191);
    @(negedge clk); i_valid = 1'b0; #1;
    chk("full_o_valid", int'(ov[0]), 1);
    chk("full_i_ready", int'(ir[0]), 0);
    chk("full_sticky", int'(st[1]), 1);
    rst_n = 1'b0; #1;
    chk("rst_low_i_ready", int'(ir[0]), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("midrst_o_valid", int'(ov[0]), 0);
    chk("midrst_o_data", int'(od[1]), 0);
    chk("midrst_cnt", sc_of(1), 0);
    chk("midrst_sticky", int'(st[1]), 0);
    chk("midrst_i_ready", int'(ir[0]), 1);
    o_ready = 1'b1; i_valid = 1'b1; i_data = 14'(80);
    @(negedge clk); i_valid = 1'b0; #1;
    chk("post_rst_lat1", int'(ov[0]), 0);
    @(negedge clk); #1;
    chk("post_rst_lat2", int'(ov[0]), 1);
    for (int k = 0; k < 5; k++) chk("post_rst_data", int'($signed(od[k])), 10);
    @(negedge clk); #1;
    chk("post_rst_drain", int'(ov[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fx_narrow_pipe.md
# fx_narrow_pipe

Pipelined signed fixed-point narrowing converter. Requantizes a wide two's-complement sample (IW bits, IFRAC fractional) to a narrower format (OW bits, OFRAC fractional). The quantization stage drops LSBs with selectable rounding. The overflow stage reduces MSBs with selectable saturation or wrap. Sits on the reduction side of a datapath, where FxMatch-style widening blocks sit on the expansion side. Uses valid/ready flow control and keeps overflow statistics.

## Interface
- IW, 14, input width
- IFRAC, 6, input fractional bits
- OW, 10, output width
- OFRAC, 3, output fractional bits
- ROUND_MODE, 1, 0 = truncate (floor), 1 = round-half-up, 2 = round-half-even
- SAT_MODE, 1, 0 = wrap, 1 = saturate
- CNT_W, 16, overflow counter width
- Legal parameters: IFRAC >= OFRAC and IW-IFRAC >= OW-OFRAC. Let D = IFRAC-OFRAC.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_data  in  IW  signed input sample
- i_valid  in  1  input sample valid
- i_ready  out  1  block accepts input
- o_data  out  OW  signed output sample
- o_valid  out  1  output valid
- o_ready  in  1  downstream accepts output
- o_sat  out  1  overflow flag for the current o_data
- sat_cnt  out  CNT_W  count of overflowed samples, saturating at all-ones
- ovf_sticky  out  1  set on any overflow, held until cleared
- clr  in  1  one-cycle synchronous clear of sat_cnt and ovf_sticky

## Operation
- **Stage 1 (quantize):**
  - Sign-extend i_data to IW+1 bits.
  - Truncate: arithmetic shift right by D.
  - Half-up: add 2^(D-1), then shift.
  - Half-even: add 2^(D-1)-1 plus bit D of the input, then shift.
  - D=0: pass through, no rounding.
  - Result q has IW-D+1 bits, so no internal overflow.
- **Stage 2 (overflow):**
  - ovf = 1 when q lies outside [-2^(OW-1), 2^(OW-1)-1].
  - Saturate mode: clamp to 2^(OW-1)-1 or -2^(OW-1).
  - Wrap mode: keep the low OW bits.
  - o_sat = ovf in both modes.
- **Statistics:**
  - Update when a sample with ovf=1 loads into the stage-2 register: sat_cnt += 1 unless already all-ones; ovf_sticky = 1.
  - clr zeroes both.
  - clr in the same cycle as a counted load: result is sat_cnt=1, ovf_sticky=1 (clear first, then count).
- **Flow control:**
  - Two-register pipeline with valid bits s1_v and s2_v; o_valid = s2_v.
  - Stage 2 loads when s1_v && (!s2_v || o_ready).
  - i_ready = rst_n && (!s1_v || !s2_v || o_ready).
  - Input transfers when i_valid && i_ready.
  - Full throughput (one sample per cycle) while o_ready=1.
  - While o_valid=1 && o_ready=0, o_data and o_sat hold stable.
- **Reset (rst_n=0 at a clock edge):**
  - o_valid=0, o_data=0, o_sat=0, sat_cnt=0, ovf_sticky=0, both valid bits cleared.
  - i_ready=0 while rst_n is low.
  - Reset mid-stream discards all in-flight samples. No partial output appears after release.

## Timing
- Latency: 2 cycles from input transfer to o_valid, when not stalled.
- After reset release, i_ready=1 in the first cycle.
- Stall of k cycles adds k cycles to latency. No sample is lost or duplicated.
- Stats update 1 cycle after the stage-1-to-stage-2 transfer, visible in the same cycle as o_valid/o_sat for that sample.
- i_valid may drop at any cycle without affecting queued samples.
- The input side must hold i_data stable while i_valid && !i_ready.

## Test plan
All scenarios use defaults IW=14, IFRAC=6, OW=10, OFRAC=3 (D=3) unless stated.
- **Rounding modes:** drive i_data=20, then -20, then 12.
  - Half-up outputs 3, -2, 2.
  - Half-even outputs 2, -2, 2.
  - Truncate outputs 2, -3, 1.
  - o_sat=0 for all.
- **Overflow:** i_data=8191 then -8192, SAT_MODE=1.
  - Outputs 10'h1FF and 10'h200, o_sat=1 on both, sat_cnt=2, ovf_sticky=1.
  - With SAT_MODE=0, outputs 0 and 0, sat_cnt=2.
- **Rounding-induced overflow:** i_data=4092.
  - Half-up gives 511 saturated with o_sat=1.
  - Truncate gives 511 with o_sat=0.
- **Backpressure:** stream 0..15×8 with o_ready toggling 1,0,0,1 …
  - Outputs are 0..15 in order, each held stable while stalled.
  - i_ready drops only when both stages are full and o_ready=0.
- **Counter:** CNT_W=2, five overflowing samples.
  - sat_cnt sticks at 3.
  - clr together with a sixth overflowing load gives sat_cnt=1 and ovf_sticky=1.
- **Reset mid-stream:** assert rst_n=0 for 1 cycle with both stages full.
  - Next cycle o_valid=0, sat_cnt=0.
  - First new input appears 2 cycles after acceptance.
